// File: rtl/pos_step_sequencer_pkg.sv
// Shared types for the X/Y position step sequencer: FSM states, axis encoding,
// slice width and the per-axis request payload.
package pos_seq_pkg;

  localparam int unsigned SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    AX_X = 1'b0,
    AX_Y = 1'b1
  } axis_t;

  typedef struct packed {
    logic               dir;
    logic [SLICE_W-1:0] step;
  } step_req_t;

endpackage

// File: rtl/pos_step_sequencer_if.sv
// Request/ack and position bus between the step generators (master) and the
// sequencer (slave).
interface pos_step_sequencer_if
  import pos_seq_pkg::*;
#(
  parameter int unsigned POS_W = 9
);
  logic               x_req;
  logic               x_dir;
  logic [SLICE_W-1:0] x_step;
  logic               x_ack;
  logic               y_req;
  logic               y_dir;
  logic [SLICE_W-1:0] y_step;
  logic               y_ack;
  logic [POS_W-1:0]   pos_x;
  logic [POS_W-1:0]   pos_y;
  logic               wrap;
  logic               busy;

  modport master (
    output x_req, x_dir, x_step, y_req, y_dir, y_step,
    input  x_ack, y_ack, pos_x, pos_y, wrap, busy
  );

  modport slave (
    input  x_req, x_dir, x_step, y_req, y_dir, y_step,
    output x_ack, y_ack, pos_x, pos_y, wrap, busy
  );
endinterface

// File: rtl/pos_step_sequencer_slice_adder3.sv
// 3-bit slice adder with carry-in/out; one instance is time-shared by both axes.
module slice_adder3
  import pos_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);
  assign {co, s} = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(ci);
endmodule

// File: rtl/pos_step_sequencer.sv
// Round-robin X/Y position updater, one 3-bit slice per clock through a shared
// slice adder. Define POS_SAT_EN to saturate instead of wrap on over/underflow.
module pos_step_sequencer
  import pos_seq_pkg::*;
#(
  parameter int unsigned POS_W = 9
)
(
  input  logic           clk,
  input  logic           rst_n,
  pos_step_sequencer_if.slave bus
);
  localparam int unsigned NSLICE = POS_W / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_d;
  axis_t              axis_q, axis_d, last_grant_q, last_grant_d;
  logic               dir_q, dir_d, carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   opb_q, opb_d, shadow_q, shadow_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic               x_ack_q, x_ack_d, y_ack_q, y_ack_d;
  logic               wrap_q, wrap_d, busy_q, busy_d;

  step_req_t          x_op, y_op, g_op;
  logic               grant_x, grant_y, wrap_c;
  logic [POS_W-1:0]   pos_sel, commit;
  logic [SLICE_W-1:0] sl_a, sl_s;
  logic               sl_co;

  // Round-robin: on a tie the axis not granted last wins
  assign x_op    = {bus.x_dir, bus.x_step};
  assign y_op    = {bus.y_dir, bus.y_step};
  assign grant_x = bus.x_req & (~bus.y_req | (last_grant_q == AX_Y));
  assign grant_y = bus.y_req & ~grant_x;
  assign g_op    = grant_x ? x_op : y_op;

  assign pos_sel = (axis_q == AX_Y) ? pos_y_q : pos_x_q;
  assign sl_a    = SLICE_W'(pos_sel >> (32'(idx_q) * SLICE_W));
  assign wrap_c  = dir_q ^ carry_q;

  slice_adder3 u_slice (
    .a  (sl_a),
    .b  (opb_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Value committed in DONE; saturation replaces the wrapped result when enabled
  always_comb begin
`ifdef POS_SAT_EN
    commit = wrap_c ? (dir_q ? '0 : '1) : shadow_q;
`else
    commit = shadow_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    axis_d       = axis_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    opb_d        = opb_q;
    shadow_d     = shadow_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    x_ack_d      = 1'b0;
    y_ack_d      = 1'b0;
    wrap_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_x || grant_y) begin
          axis_d  = grant_x ? AX_X : AX_Y;
          dir_d   = g_op.dir;
          opb_d   = POS_W'(g_op.step) ^ {POS_W{g_op.dir}};
          carry_d = g_op.dir;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Slice results shift in from the top so slice 0 lands at bit 0
        shadow_d = POS_W'({sl_s, shadow_q} >> SLICE_W);
        opb_d    = opb_q >> SLICE_W;
        carry_d  = sl_co;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NSLICE - 1)) state_d = DONE;
      end
      DONE: begin
        if (axis_q == AX_X) begin
          pos_x_d = commit;
          x_ack_d = 1'b1;
        end else begin
          pos_y_d = commit;
          y_ack_d = 1'b1;
        end
        wrap_d       = wrap_c;
        last_grant_d = axis_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      axis_q       <= AX_X;
      last_grant_q <= AX_Y;
      dir_q        <= 1'b0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      opb_q        <= '0;
      shadow_q     <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      x_ack_q      <= 1'b0;
      y_ack_q      <= 1'b0;
      wrap_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      axis_q       <= axis_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      opb_q        <= opb_d;
      shadow_q     <= shadow_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      x_ack_q      <= x_ack_d;
      y_ack_q      <= y_ack_d;
      wrap_q       <= wrap_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.x_ack = x_ack_q;
  assign bus.y_ack = y_ack_q;
  assign bus.pos_x = pos_x_q;
  assign bus.pos_y = pos_y_q;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_pos_step_sequencer.sv
// Directed bench for pos_step_sequencer (POS_W = 9); expected values follow
// POS_SAT_EN when it is defined for the build.
module tb_pos_step_sequencer;

  localparam int ACK_LAT   = 4;
  localparam int GRANT_GAP = 5;
`ifdef POS_SAT_EN
  localparam int UNDER_Y = 0;
  localparam int OVER_X  = 511;
`else
  localparam int UNDER_Y = 511;
  localparam int OVER_X  = 5;
`endif

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_x = 0;
  int   exp_y = 0;

  pos_step_sequencer_if #(.POS_W(9)) bus ();

  pos_step_sequencer #(.POS_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request on one axis; checks latency, both positions, wrap and ack width
  task automatic do_op(input bit ax, input bit dir, input logic [2:0] step,
                       input int exp_pos, input int exp_other, input int exp_wrap);
    int   lat;
    bit   seen;
    logic ack;
    @(negedge clk);
    if (ax) begin
      bus.y_req = 1'b1; bus.y_dir = dir; bus.y_step = step;
    end else begin
      bus.x_req = 1'b1; bus.x_dir = dir; bus.x_step = step;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      ack = ax ? bus.y_ack : bus.x_ack;
      if (lat == 2) check("busy_mid_add", 32'(bus.busy), 32'd1);
      if (ack === 1'b1) seen = 1'b1;
    end
    check("ack_latency", 32'(lat - 1), 32'(ACK_LAT));
    check("pos_granted", 32'(ax ? bus.pos_y : bus.pos_x), 32'(exp_pos));
    check("pos_other", 32'(ax ? bus.pos_x : bus.pos_y), 32'(exp_other));
    check("wrap", 32'(bus.wrap), 32'(exp_wrap));
    if (ax) bus.y_req = 1'b0; else bus.x_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(ax ? bus.y_ack : bus.x_ack), 32'd0);
    check("wrap_one_cycle", 32'(bus.wrap), 32'd0);
  endtask

  initial begin
    int n;
    int acks;
    int ax_seq [4];
    int ack_cyc [4];
    bit x_drop, y_drop;

    rst_n = 1'b0;
    bus.x_req = 1'b0; bus.x_dir = 1'b0; bus.x_step = 3'd0;
    bus.y_req = 1'b0; bus.y_dir = 1'b0; bus.y_step = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_pos_x", 32'(bus.pos_x), 32'd0);
    check("rst_pos_y", 32'(bus.pos_y), 32'd0);
    check("rst_x_ack", 32'(bus.x_ack), 32'd0);
    check("rst_y_ack", 32'(bus.y_ack), 32'd0);
    check("rst_wrap", 32'(bus.wrap), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of ADD discards the operation
    @(negedge clk);
    bus.x_req = 1'b1; bus.x_dir = 1'b0; bus.x_step = 3'd5;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pos_x", 32'(bus.pos_x), 32'd0);
    @(negedge clk);
    bus.x_req = 1'b0;
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.x_ack === 1'b1 || bus.y_ack === 1'b1) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'd0);
    check("abort_pos_x_after", 32'(bus.pos_x), 32'd0);
    check("abort_pos_y_after", 32'(bus.pos_y), 32'd0);

    // Simple add, then build up to 63
    exp_x = 5;
    do_op(1'b0, 1'b0, 3'd5, exp_x, exp_y, 0);
    for (int i = 0; i < 8; i++) begin
      exp_x += 7;
      do_op(1'b0, 1'b0, 3'd7, exp_x, exp_y, 0);
    end
    exp_x = 63;
    do_op(1'b0, 1'b0, 3'd2, exp_x, exp_y, 0);

    // Carry chain across slices 0 and 1, both directions
    exp_x = 64;
    do_op(1'b0, 1'b0, 3'd1, exp_x, exp_y, 0);
    exp_x = 63;
    do_op(1'b0, 1'b1, 3'd1, exp_x, exp_y, 0);

    // Underflow on Y
    exp_y = UNDER_Y;
    do_op(1'b1, 1'b1, 3'd1, exp_y, exp_x, 1);

    // Climb X to 510, then overflow by 7
    for (int i = 0; i < 63; i++) begin
      exp_x += 7;
      do_op(1'b0, 1'b0, 3'd7, exp_x, exp_y, 0);
    end
    exp_x = 510;
    do_op(1'b0, 1'b0, 3'd6, exp_x, exp_y, 0);
    exp_x = OVER_X;
    do_op(1'b0, 1'b0, 3'd7, exp_x, exp_y, 1);

    // Arbitration: both requesting out of reset, each re-raises after its ack
    @(negedge clk);
    rst_n = 1'b0;
    bus.x_req = 1'b1; bus.x_dir = 1'b0; bus.x_step = 3'd1;
    bus.y_req = 1'b1; bus.y_dir = 1'b0; bus.y_step = 3'd1;
    #1;
    check("rst2_pos_x", 32'(bus.pos_x), 32'd0);
    check("rst2_pos_y", 32'(bus.pos_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    x_drop = 1'b0;
    y_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ax_seq[i]  = -1;
      ack_cyc[i] = -100;
    end
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (x_drop) begin bus.x_req = 1'b1; x_drop = 1'b0; end
      if (y_drop) begin bus.y_req = 1'b1; y_drop = 1'b0; end
      if (bus.x_ack === 1'b1 && bus.y_ack === 1'b1) check("arb_dual_ack", 32'd1, 32'd0);
      if (bus.x_ack === 1'b1 && n < 4) begin
        ax_seq[n] = 0; ack_cyc[n] = cyc; n++;
        bus.x_req = 1'b0; x_drop = 1'b1;
      end else if (bus.y_ack === 1'b1 && n < 4) begin
        ax_seq[n] = 1; ack_cyc[n] = cyc; n++;
        bus.y_req = 1'b0; y_drop = 1'b1;
      end
    end
    bus.x_req = 1'b0;
    bus.y_req = 1'b0;
    check("arb_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check("arb_order", 32'(ax_seq[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++) check("arb_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(GRANT_GAP));
    repeat (8) @(negedge clk);
    check("arb_pos_x", 32'(bus.pos_x), 32'd2);
    check("arb_pos_y", 32'(bus.pos_y), 32'd2);
    check("arb_idle_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
